// File: rtl/regfile_sb.sv
// Register file with write-back source mux, write-to-read bypass and a
// pending-write scoreboard that feeds per-port busy flags to the hazard unit.
module regfile_sb #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rr1_addr_i,
    input  logic [AW-1:0] rr2_addr_i,
    output logic [DW-1:0] rd1_o,
    output logic [DW-1:0] rd2_o,
    output logic          rd1_busy_o,
    output logic          rd2_busy_o,
    input  logic          iss_valid_i,
    input  logic [AW-1:0] iss_rd_i,
    input  logic          flush_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [1:0]    wb_sel_i,
    input  logic [DW-1:0] wb_alu_i,
    input  logic [DW-1:0] wb_mem_i,
    input  logic [DW-1:0] wb_imm_i,
    input  logic [DW-1:0] wb_pc4_i,
    output logic [DW-1:0] wb_data_o,
    output logic [AW:0]   busy_cnt_o
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [DW-1:0]   wb_data;
    logic            wb_commit;

    always_comb begin
        wb_data = wb_alu_i;
        case (wb_sel_i)
            2'b00: wb_data = wb_alu_i;
            2'b01: wb_data = wb_mem_i;
            2'b10: wb_data = wb_imm_i;
            2'b11: wb_data = wb_pc4_i;
        endcase
    end

    assign wb_data_o = wb_data;
    assign wb_commit = wb_we_i && (wb_addr_i != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_commit) begin
            regs_q[wb_addr_i] <= wb_data;
        end
    end

    // A write-back in flight supplies the value, so it also hides the busy mark.
    always_comb begin
        rd1_o      = '0;
        rd1_busy_o = 1'b0;
        if (rr1_addr_i != '0) begin
            if (wb_we_i && (wb_addr_i == rr1_addr_i)) begin
                rd1_o = wb_data;
            end else begin
                rd1_o      = regs_q[rr1_addr_i];
                rd1_busy_o = busy_q[rr1_addr_i];
            end
        end
    end

    always_comb begin
        rd2_o      = '0;
        rd2_busy_o = 1'b0;
        if (rr2_addr_i != '0) begin
            if (wb_we_i && (wb_addr_i == rr2_addr_i)) begin
                rd2_o = wb_data;
            end else begin
                rd2_o      = regs_q[rr2_addr_i];
                rd2_busy_o = busy_q[rr2_addr_i];
            end
        end
    end

    // Set beats clear on the same register: the newer producer owns it.
    always_comb begin
        busy_d = '0;
        if (!flush_i) begin
            for (int i = 1; i < NREG; i++) begin
                busy_d[i] = (iss_valid_i && (iss_rd_i == AW'(i)))
                          || (busy_q[i] && !(wb_we_i && (wb_addr_i == AW'(i))));
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 1; i < NREG; i++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt_o = cnt_q;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a write-back source mux, same-cycle write-to-read bypass, and a per-register pending-write scoreboard. It sits between decode (read/issue side) and write-back in the pipeline. It exposes per-port busy flags so the hazard unit can stall on in-flight producers.

## Interface
- DW, 32, data width in bits
- AW, 5, register address width; NREG = 2**AW registers
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rr1_addr, rr2_addr  in  AW  read port addresses
- rd1, rd2  out  DW  read data, combinational
- rd1_busy, rd2_busy  out  1  addressed register has a pending write not yet satisfied by the current write-back
- iss_valid  in  1  instruction issuing this cycle with a destination
- iss_rd  in  AW  destination of issuing instruction
- flush  in  1  clear all pending-write marks
- wb_we  in  1  write-back enable
- wb_addr  in  AW  write-back destination
- wb_sel  in  2  write-back source: 00 wb_alu, 01 wb_mem, 10 wb_imm, 11 wb_pc4
- wb_alu, wb_mem, wb_imm, wb_pc4  in  DW  write-back candidates
- wb_data  out  DW  selected write-back value, combinational
- busy_cnt  out  AW+1  number of registers currently marked pending, registered

## Operation
- Register 0 reads 0, ignores writes, and is never marked busy. iss_rd==0 and wb_addr==0 are no-ops for state.
- wb_data = mux(wb_sel) as above; all four codes are defined. There is no default-zero case.
- Write: on a rising edge with wb_we=1 and wb_addr!=0, reg[wb_addr] <= wb_data.
- Read bypass: rdN = 0 if rrN_addr==0. Otherwise rdN = wb_data if wb_we and wb_addr==rrN_addr. Otherwise rdN = reg[rrN_addr].
- Scoreboard busy[NREG-1:1] is updated at each rising edge in the following priority:
  - flush=1: all bits cleared. Any iss_valid in that cycle is also discarded.
  - Otherwise a bit is set if iss_valid and iss_rd==i. It is cleared if wb_we and wb_addr==i and it is not being set.
  - When set and clear hit the same register in the same cycle, set wins: a newer producer supersedes.
- rdN_busy = busy[rrN_addr] and not (wb_we and wb_addr==rrN_addr). The current write-back satisfies the hazard through the bypass. rdN_busy is 0 for address 0.
- busy_cnt equals the popcount of busy after every edge. It is updated in the same edge as busy.
- A write-back to a non-busy register is legal. It writes the data and leaves busy unchanged at 0.

## Timing
- Reset (asynchronous, rst_n=0): all registers 0, busy all 0, busy_cnt 0. rd1/rd2 read 0 unless a bypass is active. Reset is honoured mid-operation; any pending marks are lost.
- Read latency is 0 cycles (combinational). Write latency is 1 edge; the bypass covers the write cycle itself.
- Issue mark is visible on rdN_busy from the cycle after iss_valid.
- Clear is visible from the write-back cycle itself via the bypass term, and is committed at the edge.
- flush takes effect at the edge. busy flags already asserted in the flush cycle remain visible combinationally until then.
- There is no handshake or backpressure. The hazard unit must hold issue while rdN_busy=1.

## Test plan
- **Reset and zero register:** assert rst_n=0 mid-run with busy_cnt=3, then release. Required: all reads 0, busy_cnt=0. Then write 0xDEADBEEF to r0; reading r0 returns 0 and rd1_busy=0.
- **Source mux:** for wb_sel 00/01/10/11 with alu=1, mem=2, imm=3, pc4=4, write r5 each cycle. Required: wb_data equals 1, 2, 3, 4, and r5 reads back 4.
- **Bypass:** r7=0x11, then write r7=0x22 while rr1_addr=7. Required: rd1=0x22 in the same cycle and 0x22 after the edge. rr2_addr=8 is unaffected.
- **Scoreboard lifecycle:** issue r3. Next cycle rr1_addr=3 gives rd1_busy=1 and busy_cnt=1. Write-back r3=0x55 gives rd1_busy=0 in that cycle with rd1=0x55. After the edge, busy_cnt=0.
- **Simultaneous set/clear:** issue r9 while write-back r9 (previously busy) in the same cycle. Required: after the edge, busy[9]=1 and busy_cnt unchanged. A second write-back clears it.
- **Flush:** mark r1, r2 and r4 busy (busy_cnt=3), then assert flush together with iss_valid on r6. Required: after the edge, busy_cnt=0 and r6 is not busy. Register contents are unchanged.
